c2c_r_arbiter: RTL and testbench

Two-requester arbiter that shares a single core-to-cache read port (`c2c_r`) between the instruction-fetch unit and the load unit. Each requester sees an ordinary `c2c_r` slave. The arbiter registers the winning request and drives one `c2c_r` master toward the cache until `ack` returns. Grants alternate round-robin, so a continuously requesting port cannot starve the other.

---
 rtl/c2c_pkg.sv | 9 +
 rtl/c2c_r_if.sv | 13 +
 rtl/c2c_rr_pick.sv | 14 +
 rtl/c2c_r_arbiter.sv | 84 ++++++++
 tb/tb_c2c_r_arbiter.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/c2c_pkg.sv
// Shared types for the core-to-cache arbiters (read side today, write side later).
package c2c_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/c2c_r_if.sv
// Core-to-cache read link: master holds re/addr/sel until the slave pulses ack with data.
interface c2c_r #(
   parameter int XLEN = 32
);
   logic                re;
   logic [XLEN-1:0]     addr;
   logic [XLEN/8-1:0]   sel;
   logic                ack;
   logic [XLEN-1:0]     data;

   modport master (output re, addr, sel, input ack, data);
   modport slave  (input re, addr, sel, output ack, data);
endinterface

// File: rtl/c2c_rr_pick.sv
// Combinational 2-way round-robin picker; on contention the port that did not win last time wins.
module c2c_rr_pick (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       valid
);

   always_comb begin
      valid = |req;
      gnt   = (req == 2'b11) ? ~last : req[1];
   end

endmodule

// File: rtl/c2c_r_arbiter.sv
// Shares one c2c_r master port between instruction fetch (req0) and the load unit (req1).
module c2c_r_arbiter
   import c2c_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic  clk,
   input  logic  rst_n,
   c2c_r.slave   req0,
   c2c_r.slave   req1,
   c2c_r.master  cache
);

   arb_state_t          state;
   arb_state_t          state_next;
   logic                last;
   logic                gnt;
   logic                pick_gnt;
   logic                pick_valid;
   logic                load;
   logic                done;
   logic [XLEN-1:0]     addr_q;
   logic [XLEN/8-1:0]   sel_q;

   c2c_rr_pick u_pick (
      .req   ({req1.re, req0.re}),
      .last  (last),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_next = BUSY;
               load       = 1'b1;
            end
         end
         BUSY: begin
            if (cache.ack) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // last resets to 1 so requester 0 wins the first contention after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last   <= 1'b1;
         gnt    <= 1'b0;
         addr_q <= '0;
         sel_q  <= '0;
      end else begin
         if (load) begin
            gnt    <= pick_gnt;
            addr_q <= pick_gnt ? req1.addr : req0.addr;
            sel_q  <= pick_gnt ? req1.sel  : req0.sel;
         end
         if (done) last <= gnt;
      end
   end

   assign cache.re   = (state == BUSY);
   assign cache.addr = addr_q;
   assign cache.sel  = sel_q;

   assign req0.ack   = done & ~gnt;
   assign req1.ack   = done &  gnt;
   assign req0.data  = cache.data;
   assign req1.data  = cache.data;

endmodule

// File: tb/tb_c2c_r_arbiter.sv
// Directed bench for c2c_r_arbiter with a small cache responder of configurable ack latency.
module tb_c2c_r_arbiter;

   logic        clk;
   logic        rst_n;
   int          vecCount;
   int          missCount;
   int          lat;
   int          cnt;
   logic        autoAck;
   logic        manualAck;
   logic [31:0] rspData;

   c2c_r #(.XLEN(32)) r0 ();
   c2c_r #(.XLEN(32)) r1 ();
   c2c_r #(.XLEN(32)) cc ();

   c2c_r_arbiter #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req0  (r0),
      .req1  (r1),
      .cache (cc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Responder: ack once cache.re has been seen high for 'lat' cycles
   initial begin
      cc.ack  = 1'b0;
      cc.data = '0;
      cnt     = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!autoAck) begin
            cc.ack = manualAck;
            cnt    = 0;
         end else if (!rst_n || cc.ack) begin
            cc.ack = 1'b0;
            cnt    = 0;
         end else if (cc.re) begin
            cnt++;
            if (cnt >= lat) cc.ack = 1'b1;
         end
         cc.data = rspData;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic re0, input logic [31:0] a0, input logic [3:0] s0,
                                input logic re1, input logic [31:0] a1, input logic [3:0] s1);
      @(posedge clk);
      #1;
      r0.re = re0; r0.addr = a0; r0.sel = s0;
      r1.re = re1; r1.addr = a1; r1.sel = s1;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      lat       = 3;
      autoAck   = 1'b1;
      manualAck = 1'b0;
      rspData   = 32'h0;
      rst_n     = 1'b0;
      r0.re = 1'b0; r0.addr = '0; r0.sel = '0;
      r1.re = 1'b0; r1.addr = '0; r1.sel = '0;

      repeat (2) step();
      checkOutput("rst_cache_re", {31'd0, cc.re}, 32'd0);
      checkOutput("rst_ack0", {31'd0, r0.ack}, 32'd0);
      checkOutput("rst_ack1", {31'd0, r1.ack}, 32'd0);
      checkOutput("rst_addr", cc.addr, 32'd0);
      checkOutput("rst_sel", {28'd0, cc.sel}, 32'd0);
      rst_n   = 1'b1;
      rspData = 32'hDEAD_BEEF;

      // Single request from port 0, ack in the third BUSY cycle
      applyStimulus(1'b1, 32'h0000_1000, 4'hF, 1'b0, 32'h0, 4'h0);
      step();
      checkOutput("t1_idle_re", {31'd0, cc.re}, 32'd0);
      step();
      checkOutput("t1_re_rise", {31'd0, cc.re}, 32'd1);
      checkOutput("t1_addr", cc.addr, 32'h0000_1000);
      checkOutput("t1_sel", {28'd0, cc.sel}, 32'hF);
      checkOutput("t1_ack0_b1", {31'd0, r0.ack}, 32'd0);
      step();
      checkOutput("t1_ack0_b2", {31'd0, r0.ack}, 32'd0);
      step();
      checkOutput("t1_ack0", {31'd0, r0.ack}, 32'd1);
      checkOutput("t1_data0", r0.data, 32'hDEAD_BEEF);
      checkOutput("t1_ack1", {31'd0, r1.ack}, 32'd0);
      checkOutput("t1_data1", r1.data, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      step();
      checkOutput("t1_back_idle", {31'd0, cc.re}, 32'd0);

      // Contention: fresh reset, latency 1, grants must alternate starting at 0
      rst_n = 1'b0;
      lat   = 1;
      step();
      rst_n = 1'b1;
      applyStimulus(1'b1, 32'h100, 4'h1, 1'b1, 32'h200, 4'h2);
      for (int i = 0; i < 8; i++) begin
         step();
         checkOutput($sformatf("t2_idle_noack_%0d", i), {31'd0, r0.ack | r1.ack}, 32'd0);
         step();
         checkOutput($sformatf("t2_ack0_%0d", i), {31'd0, r0.ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
         checkOutput($sformatf("t2_ack1_%0d", i), {31'd0, r1.ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
         checkOutput($sformatf("t2_addr_%0d", i), cc.addr, (i % 2 == 0) ? 32'h100 : 32'h200);
      end
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);

      // Address stability: port 1 changes addr while granted
      lat = 3;
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 32'h40, 4'h3);
      step();
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 32'h80, 4'hC);
      step();
      checkOutput("t3_addr_b1", cc.addr, 32'h40);
      checkOutput("t3_sel_b1", {28'd0, cc.sel}, 32'h3);
      step();
      checkOutput("t3_addr_b2", cc.addr, 32'h40);
      step();
      checkOutput("t3_ack1", {31'd0, r1.ack}, 32'd1);
      checkOutput("t3_addr_b3", cc.addr, 32'h40);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h80, 4'hC);

      // Withdrawn request: port 0 drops re after grant, port 1 then waits
      applyStimulus(1'b1, 32'h300, 4'hF, 1'b0, 32'h0, 4'h0);
      step();
      applyStimulus(1'b0, 32'h300, 4'hF, 1'b1, 32'h500, 4'hF);
      step();
      checkOutput("t4_re_b1", {31'd0, cc.re}, 32'd1);
      checkOutput("t4_addr", cc.addr, 32'h300);
      step();
      checkOutput("t4_re_b2", {31'd0, cc.re}, 32'd1);
      step();
      checkOutput("t4_ack0", {31'd0, r0.ack}, 32'd1);
      checkOutput("t4_ack1_quiet", {31'd0, r1.ack}, 32'd0);
      step();
      checkOutput("t4_idle_re", {31'd0, cc.re}, 32'd0);
      step();
      checkOutput("t4_addr_next", cc.addr, 32'h500);
      checkOutput("t4_ack1_b1", {31'd0, r1.ack}, 32'd0);
      step();
      step();
      checkOutput("t4_ack1", {31'd0, r1.ack}, 32'd1);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);

      // Reset mid-transfer drops cache.re asynchronously, then port 0 wins contention
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b1, 32'h600, 4'hF);
      step();
      step();
      checkOutput("t5_busy_re", {31'd0, cc.re}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_async_re", {31'd0, cc.re}, 32'd0);
      checkOutput("t5_async_ack0", {31'd0, r0.ack}, 32'd0);
      checkOutput("t5_async_ack1", {31'd0, r1.ack}, 32'd0);
      lat = 1;
      applyStimulus(1'b1, 32'h700, 4'hF, 1'b1, 32'h600, 4'hF);
      step();
      rst_n = 1'b1;
      step();
      checkOutput("t5_ack0", {31'd0, r0.ack}, 32'd1);
      checkOutput("t5_ack1", {31'd0, r1.ack}, 32'd0);
      checkOutput("t5_addr", cc.addr, 32'h700);
      applyStimulus(1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
      step();

      // Stray cache ack while idle
      autoAck   = 1'b0;
      manualAck = 1'b1;
      step();
      checkOutput("t6_stray_cache_ack", {31'd0, cc.ack}, 32'd1);
      checkOutput("t6_ack0", {31'd0, r0.ack}, 32'd0);
      checkOutput("t6_ack1", {31'd0, r1.ack}, 32'd0);
      checkOutput("t6_re", {31'd0, cc.re}, 32'd0);
      manualAck = 1'b0;
      step();
      checkOutput("t6_still_idle", {31'd0, cc.re}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
